sort_frame_loader: RTL
======================

// Module: sort_frame_loader
// PURPOSE
//  Upstream feeder for bitonic_sorter. Collects a valid/ready word stream into one SORT_SIZE-wide frame.
//  Pads short frames with the maximum value so pads sort to the top.
//  Presents each completed frame, with a valid/ready handshake, on the sorter's data_in vector.
//  One frame is buffered at a time.
// PARAMETERS
//  SORT_SIZE   16          words per frame; power of two, >= 2 (matches sorter)
//  DATA_WIDTH  64          bits per word
//  PAD_VALUE   '1 (all 1s) fill for unused slots; sorts last in ascending order
//  CNT_W       $clog2(SORT_SIZE+1)  derived; width of word counts
// PORTS
//  clk         in   1                       clock, rising edge
//  rst         in   1                       asynchronous, active-high reset
//  in_valid    in   1                       input word valid
//  in_ready    out  1                       loader can accept a word
//  in_data     in   DATA_WIDTH              input word
//  in_last     in   1                       final word of the current frame
//  frame_valid out  1                       frame_data holds a complete frame
//  frame_ready in   1                       consumer takes the frame; tie 1 for a free-running sorter
//  frame_data  out  [SORT_SIZE-1:0][DATA_WIDTH-1:0]  frame to the sorter's data_in
//  frame_count out  CNT_W                   number of real (non-pad) words, 1..SORT_SIZE
//  frame_nolast out 1                       frame closed on size limit without in_last
// BEHAVIOUR
//  Reset:
//   - Asynchronous, active-high; legal mid-operation.
//   - State=FILL, wr_ptr=0, frame_data=0, frame_count=0, frame_valid=0, frame_nolast=0.
//   - in_ready=1 on the first clock after rst deasserts.
//   - A partially filled frame is discarded.
//  FSM states: FILL -> (PAD) -> PRESENT -> FILL.
//  FILL:
//   - in_ready=1.
//   - On in_valid&&in_ready, in_data is written to slot wr_ptr and wr_ptr increments.
//   - Word accepted with wr_ptr==SORT_SIZE-1: go to PRESENT. frame_nolast = !in_last.
//   - Word accepted with in_last and wr_ptr<SORT_SIZE-1: go to PAD.
//  PAD (exactly one cycle):
//   - in_ready=0.
//   - Every slot >= frame_count is set to PAD_VALUE in a single cycle.
//  PRESENT:
//   - frame_valid=1, in_ready=0.
//   - frame_data, frame_count and frame_nolast stay stable until frame_ready is sampled high.
//   - On frame_valid&&frame_ready: go to FILL, wr_ptr=0. frame_data keeps its old contents until overwritten.
//  Latency from accepting the closing word to frame_valid:
//   - Full frame: 1 cycle.
//   - Short frame: 2 cycles.
//  No word is ever dropped or duplicated. in_ready is a registered function of state only.
//  After frame_nolast, the next accepted word starts a new frame.
//  in_last on a word at slot SORT_SIZE-1 gives a full frame with frame_nolast=0.
//  frame_count = wr_ptr+1 at close. A single-word frame is legal: count=1, SORT_SIZE-1 pads.
// CONFIGURATION
//  SORT_LOADER_STATS_EN defined:
//   - Adds output stat_frames [31:0]: frames handed off.
//   - Adds output stat_pads [31:0]: total pad slots inserted.
//   - Both counters increment on handshake, wrap at 2^32, and are reset to 0 by rst.
//  SORT_LOADER_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  Package sort_pkg:
//   - word_t = logic [DATA_WIDTH-1:0].
//   - frame_t = word_t [SORT_SIZE-1:0].
//   - loader_state_e {FILL, PAD, PRESENT}.
//   - Default SORT_SIZE / DATA_WIDTH constants, shared with bitonic_sorter and the bench.
//  Sub-module sort_pad_mask:
//   - Combinational.
//   - Maps frame_count to a SORT_SIZE-bit mask of the slots that receive PAD_VALUE.
// TESTING
//  1 Full frame: 16 words 1..16, in_last on word 16 -> frame_valid 1 cycle later, frame_count=16, frame_nolast=0, data[i]=i+1.
//  2 Short frame: 3 words {5,9,2}, last on 3rd -> valid 2 cycles later, count=3, slots 3..15 = all ones.
//  3 Backpressure:
//     - Hold frame_ready=0 for 10 cycles -> frame_data stable and in_ready=0 throughout.
//     - Then frame_ready=1 -> in_ready=1 next cycle.
//  4 No last: 20 words 0..19, no in_last
//     - First frame: words 0..15, frame_nolast=1.
//     - Second frame after in_last on word 19: words 16..19, count=4.
//  5 Reset mid-fill: 7 words, then pulse rst asynchronously -> outputs zero immediately; the next frame starts at slot 0.
//  6 Stats (SORT_LOADER_STATS_EN): run scenarios 1 and 2 -> stat_frames=2, stat_pads=13.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and default sizes for the sort datapath (loader, bitonic_sorter, benches).
package sort_pkg;

    localparam int SORT_SIZE_DEFAULT  = 16;
    localparam int DATA_WIDTH_DEFAULT = 64;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] word_t;
    typedef word_t [SORT_SIZE_DEFAULT-1:0] frame_t;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PAD     = 2'd1,
        PRESENT = 2'd2
    } loader_state_e;

endpackage

// File: rtl/sort_pad_mask.sv
// Combinational map from a real-word count to the slots that must be filled with the pad value.
module sort_pad_mask
    import sort_pkg::*;
#(
    parameter  int SORT_SIZE = SORT_SIZE_DEFAULT,
    localparam int CNT_W     = $clog2(SORT_SIZE + 1)
) (
    input  logic [CNT_W-1:0]     count,
    output logic [SORT_SIZE-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < SORT_SIZE; i++) begin
            mask[i] = (i >= 32'(count));
        end
    end

endmodule

// File: rtl/sort_frame_loader.sv
// Collects a valid/ready word stream into one padded frame and hands it to bitonic_sorter.
// Optional SORT_LOADER_STATS_EN adds stat_frames / stat_pads handoff counters.
module sort_frame_loader
    import sort_pkg::*;
#(
    parameter  int                    SORT_SIZE  = SORT_SIZE_DEFAULT,
    parameter  int                    DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter  logic [DATA_WIDTH-1:0] PAD_VALUE  = '1,
    localparam int                    CNT_W      = $clog2(SORT_SIZE + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_last,
    output logic                                 frame_valid,
    input  logic                                 frame_ready,
    output logic [SORT_SIZE-1:0][DATA_WIDTH-1:0] frame_data,
    output logic [CNT_W-1:0]                     frame_count,
    output logic                                 frame_nolast
`ifdef SORT_LOADER_STATS_EN
    ,
    output logic [31:0]                          stat_frames,
    output logic [31:0]                          stat_pads
`endif
);

    localparam logic [1:0] ST_FILL    = 2'(FILL);
    localparam logic [1:0] ST_PAD     = 2'(PAD);
    localparam logic [1:0] ST_PRESENT = 2'(PRESENT);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SORT_SIZE - 1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNT_W-1:0]     wr_ptr;
    logic [SORT_SIZE-1:0] pad_mask;
    logic                 accept;
    logic                 handoff;
    logic                 at_last_slot;

    assign accept       = in_valid && in_ready;
    assign handoff      = frame_valid && frame_ready;
    assign at_last_slot = (wr_ptr == LAST_SLOT);

    sort_pad_mask #(
        .SORT_SIZE (SORT_SIZE)
    ) u_pad_mask (
        .count (frame_count),
        .mask  (pad_mask)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (at_last_slot) state_nxt = ST_PRESENT;
                    else if (in_last) state_nxt = ST_PAD;
                end
            end
            ST_PAD:     state_nxt = ST_PRESENT;
            ST_PRESENT: if (handoff) state_nxt = ST_FILL;
            default:    state_nxt = ST_FILL;
        endcase
    end

    // in_ready and frame_valid are registered from the next state so both depend on state only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_FILL;
            wr_ptr       <= '0;
            in_ready     <= 1'b0;
            frame_valid  <= 1'b0;
            frame_data   <= '0;
            frame_count  <= '0;
            frame_nolast <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready    <= (state_nxt == ST_FILL);
            frame_valid <= (state_nxt == ST_PRESENT);

            if (accept) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
                for (int unsigned i = 0; i < SORT_SIZE; i++) begin
                    if (wr_ptr == CNT_W'(i)) frame_data[i] <= in_data;
                end
                if (at_last_slot || in_last) begin
                    frame_count  <= wr_ptr + CNT_W'(1);
                    frame_nolast <= at_last_slot && !in_last;
                end
            end

            if (state == ST_PAD) begin
                for (int unsigned i = 0; i < SORT_SIZE; i++) begin
                    if (pad_mask[i]) frame_data[i] <= PAD_VALUE;
                end
            end

            if (handoff) wr_ptr <= '0;
        end
    end

`ifdef SORT_LOADER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames <= '0;
            stat_pads   <= '0;
        end else if (handoff) begin
            stat_frames <= stat_frames + 32'd1;
            stat_pads   <= stat_pads + 32'(SORT_SIZE) - 32'(frame_count);
        end
    end
`endif

endmodule
